// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: store-fed TX FIFO plus an 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;

  logic pop, push_req, push_ok, clr_ovf;
  logic not_empty, full, empty, bit_end;
  logic [7:0]  cnt8;
  logic [31:0] status;
  logic        unused;

  assign sel       = DataAdr[31:3] == BASE_ADDR[31:3];
  assign push_req  = MemWrite & sel & ~DataAdr[2];
  assign clr_ovf   = MemWrite & sel & DataAdr[2] & WriteData[3];
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign empty     = count_q == '0;
  assign not_empty = ~empty;
  assign push_ok   = push_req & (~full | pop);
  assign bit_end   = bcnt_q == BW'(CLKS_PER_BIT - 1);
  assign busy      = not_empty | (state_q != IDLE);

  // Bit 15 of the count field doubles as the parity-build flag.
  assign cnt8     = 8'(count_q);
  assign status   = {16'b0, PAR_EN, cnt8[6:0],
                     4'b0, ovf_q, busy, empty, full};
  assign ReadData = (sel & DataAdr[2]) ? status : 32'b0;
  assign unused   = &{1'b0, DataAdr[1:0], WriteData[31:8]};

  // Frame sequencing, bit timing and line drive.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx      = 1'b1;
    if (state_q != IDLE)
      bcnt_d = bit_end ? '0 : bcnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          sh_d    = mem[rptr_q];
          par_d   = ^mem[rptr_q];
          bcnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx = sh_q[0];
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        tx = par_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (not_empty) begin
            pop     = 1'b1;
            sh_d    = mem[rptr_q];
            par_d   = ^mem[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= WriteData[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop);
      if (push_req & ~push_ok) ovf_q <= 1'b1;
      else if (clr_ovf)        ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios then random store traffic,
// checked against a frame-level queue model.
module tb_mmio_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam logic [31:0] BASE = 32'h100;
`ifdef UART_TX_PARITY_EN
  localparam int  FL = 11 * C;
  localparam logic PB = 1'b1;
`else
  localparam int  FL = 10 * C;
  localparam logic PB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic        sel, tx, busy;

  int vectors = 0;
  int miscompares = 0;

  byte unsigned q[$];
  logic       active;
  int         pos;
  logic [7:0] cur;
  logic       m_ovf;

  mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .sel(sel),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [6:0] n;
    logic mb;
    n  = 7'(q.size());
    mb = active || (q.size() > 0);
    return {16'b0, PB, n, 4'b0, m_ovf, mb,
            q.size() == 0, q.size() == D};
  endfunction

  function automatic logic m_tx();
    logic [10:0] frame;
    if (!active) return 1'b1;
`ifdef UART_TX_PARITY_EN
    frame = {1'b1, ^cur, cur, 1'b0};
`else
    frame = {1'b0, 1'b1, cur, 1'b0};
`endif
    return frame[pos / C];
  endfunction

  task automatic tick(input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic rst);
    logic s, pushed, popped, setovf;
    MemWrite = we; DataAdr = a; WriteData = d; reset = rst;
    #1;
    s = (a[31:3] == BASE[31:3]);
    chk("sel", {31'b0, sel}, {31'b0, s});
    chk("ReadData", ReadData, (s && a[2]) ? m_status() : 32'b0);
    @(posedge clk);
    if (rst) begin
      q.delete(); active = 0; pos = 0; m_ovf = 0;
    end else begin
      popped = 0; setovf = 0; pushed = 0;
      if (active) begin
        if (pos == FL - 1) begin
          if (q.size() > 0) begin
            cur = q.pop_front(); pos = 0; popped = 1;
          end else active = 0;
        end else pos++;
      end else if (q.size() > 0) begin
        cur = q.pop_front(); active = 1; pos = 0; popped = 1;
      end
      if (we && s && !a[2]) begin
        if (q.size() < D) begin q.push_back(d[7:0]); pushed = 1; end
        else setovf = 1;
      end
      if (setovf) m_ovf = 1;
      else if (we && s && a[2] && d[3]) m_ovf = 0;
    end
    #1;
    chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    chk("busy", {31'b0, busy}, {31'b0, active || q.size() > 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, BASE + 32'h4, 32'h0, 1'b0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    tick(1'b1, a, d, 1'b0);
  endtask

  initial begin
    logic [31:0] adrs [5];
    active = 0; pos = 0; cur = 0; m_ovf = 0;
    MemWrite = 0; DataAdr = 0; WriteData = 0; reset = 1;
    adrs[0] = 32'h100; adrs[1] = 32'h104; adrs[2] = 32'h0FC;
    adrs[3] = 32'h108; adrs[4] = 32'h103;

    tick(1'b0, BASE + 32'h4, 0, 1'b1);
    tick(1'b0, BASE + 32'h4, 0, 1'b1);
    idle(2);

    st(32'h100, 32'hA5);
    idle(FL + 5);

    st(32'h100, 32'h11);
    st(32'h100, 32'h22);
    st(32'h100, 32'h33);
    idle(3 * FL + 5);

    for (int i = 0; i < 6; i++) st(32'h100, 32'h40 + i);
    idle(2);
    st(32'h104, 32'h8);
    idle(5 * FL + 5);

    st(32'h100, 32'h5A);
    idle(2 * C + 2);
    tick(1'b0, BASE + 32'h4, 0, 1'b1);
    idle(FL);

    for (int i = 0; i < 5; i++) st(32'h100, i);
    st(32'h104, 32'hFF);
    st(32'h0FC, 32'h77);
    idle(2);
    st(32'h104, 32'h8);
    idle(6 * FL);

    st(32'h100, 32'h07);
    idle(FL + 5);

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      tick(r < 3, adrs[$urandom_range(0, 4)], $urandom,
           $urandom_range(0, 299) == 0);
    end
    idle(6 * FL);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
